// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

   localparam int NUM_CH_DEF      = 4;
   localparam int DIV_W_DEF       = 16;
   localparam int DEFAULT_DIV_DEF = 2;

   // Divisor values at or below this mean "stop the channel".
   localparam int STOP_MAX        = 1;

   // Width of a channel index; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Divisor-write / calibration bus and divided-clock outputs of the divider.
interface clock_divider_multi_if
   import clock_divider_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DIV_W  = DIV_W_DEF
) ();

   localparam int SEL_W = sel_w(NUM_CH);

   logic              div_wr;
   logic [SEL_W-1:0]  div_wsel;
   logic [DIV_W-1:0]  div_wdata;
   logic              calib;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;

   modport master (
      output div_wr, div_wsel, div_wdata, calib,
      input  clk_out, tick, pending
   );

   modport slave (
      input  div_wr, div_wsel, div_wdata, calib,
      output clk_out, tick, pending
   );

endinterface

// File: rtl/clock_divider_ch.sv
// One divider channel: period counter, pending divisor, run flag and
// registered clock/tick outputs derived from the next-state counter.
module clock_divider_ch
   import clock_divider_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [DIV_W-1:0] i_wdata,
   input  logic             i_calib,
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_pend
);

   localparam logic [DIV_W-1:0] C_DEF  = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] C_STOP = DIV_W'(STOP_MAX);

   logic [DIV_W-1:0] r_cnt, r_div_act, r_div_pend;
   logic             r_pend, r_run, r_clk, r_tick;

   logic [DIV_W-1:0] w_cnt_nx, w_act_nx, w_pv_nx, w_apply, w_hi;
   logic             w_pend_nx, w_run_nx, w_end, w_clk_nx, w_tick_nx;

   // Next-state: period wrap/apply, pending capture, stop/restart, calib realign.
   always_comb begin
      w_cnt_nx  = r_cnt;
      w_act_nx  = r_div_act;
      w_pv_nx   = r_div_pend;
      w_pend_nx = r_pend;
      w_run_nx  = r_run;
      // A same-cycle write wins over a pending value, which wins over the active one.
      w_apply   = i_wr ? i_wdata : (r_pend ? r_div_pend : r_div_act);
      w_end     = (r_cnt == r_div_act - 1'b1);
      if (r_run) begin
         if (i_calib || w_end) begin
            w_pend_nx = 1'b0;
            w_act_nx  = w_apply;
            if (w_apply <= C_STOP) begin
               w_run_nx = 1'b0;
               w_cnt_nx = '0;
            end else begin
               // Calib parks the counter at N-1 so the next free edge wraps in phase.
               w_cnt_nx = i_calib ? (w_apply - 1'b1) : '0;
            end
         end else begin
            w_cnt_nx = r_cnt + 1'b1;
            if (i_wr) begin
               w_pv_nx   = i_wdata;
               w_pend_nx = 1'b1;
            end
         end
      end else if (i_wr && (i_wdata > C_STOP)) begin
         // Restart parks at N-1 too: clock stays low, next edge begins a period.
         w_act_nx = i_wdata;
         w_cnt_nx = i_wdata - 1'b1;
         w_run_nx = 1'b1;
      end
      w_hi      = w_act_nx - (w_act_nx >> 1);
      w_clk_nx  = w_run_nx && (w_cnt_nx < w_hi);
      w_tick_nx = w_run_nx && (w_cnt_nx == '0);
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= C_DEF - 1'b1;
         r_div_act  <= C_DEF;
         r_div_pend <= '0;
         r_pend     <= 1'b0;
         r_run      <= 1'b1;
         r_clk      <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nx;
         r_div_act  <= w_act_nx;
         r_div_pend <= w_pv_nx;
         r_pend     <= w_pend_nx;
         r_run      <= w_run_nx;
         r_clk      <= w_clk_nx;
         r_tick     <= w_tick_nx;
      end
   end

   assign o_clk  = r_clk;
   assign o_tick = r_tick;
   assign o_pend = r_pend;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent runtime-programmable clock dividers sharing one calib.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   clock_divider_multi_if.slave  bus
);

   localparam int SEL_W = sel_w(NUM_CH);

   logic [NUM_CH-1:0] w_wr, w_clk, w_tick, w_pend;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // Out-of-range selects match no channel and are dropped here.
      assign w_wr[g] = bus.div_wr && (bus.div_wsel == SEL_W'(g));

      clock_divider_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst_n   (rst_n),
         .i_wr    (w_wr[g]),
         .i_wdata (bus.div_wdata),
         .i_calib (bus.calib),
         .o_clk   (w_clk[g]),
         .o_tick  (w_tick[g]),
         .o_pend  (w_pend[g])
      );
   end

   assign bus.clk_out = w_clk;
   assign bus.tick    = w_tick;
   assign bus.pending = w_pend;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed table-driven bench for clock_divider_multi with three channels.
module tb_clock_divider_multi;

   localparam int NCH = 3;
   localparam int DW  = 8;

   typedef struct {
      logic          wr;
      logic [1:0]    sel;
      logic [DW-1:0] data;
      logic          cal;
      logic [2:0]    clk;
      logic [2:0]    tick;
      logic [2:0]    pend;
   } vec_t;

   logic clk;
   logic rst_n;
   vec_t vq[$];
   int   n_cmp;
   int   n_err;

   clock_divider_multi_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

   clock_divider_multi #(
      .NUM_CH      (NCH),
      .DIV_W       (DW),
      .DEFAULT_DIV (2)
   ) dut (
      .clk_in (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [2:0] c, input logic [2:0] t,
                          input logic [2:0] p);
      chk({nm, ".clk"},  bus.clk_out, c);
      chk({nm, ".tick"}, bus.tick,    t);
      chk({nm, ".pend"}, bus.pending, p);
   endtask

   task automatic add(input logic wr, input logic [1:0] sel, input logic [DW-1:0] data,
                      input logic cal, input logic [2:0] c, input logic [2:0] t,
                      input logic [2:0] p);
      vec_t v;
      v.wr = wr; v.sel = sel; v.data = data; v.cal = cal;
      v.clk = c; v.tick = t; v.pend = p;
      vq.push_back(v);
   endtask

   task automatic drive(input logic wr, input logic [1:0] sel, input logic [DW-1:0] data,
                        input logic cal);
      bus.div_wr    = wr;
      bus.div_wsel  = sel;
      bus.div_wdata = data;
      bus.calib     = cal;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 2'd0, '0, 1'b0);

      // Inputs apply to the edge, expected outputs are sampled just after it.
      // Defaults, N=2 everywhere.
      add(0,0,0,0, 3'b111,3'b111,3'b000);  // 1
      add(0,0,0,0, 3'b000,3'b000,3'b000);  // 2
      add(0,0,0,0, 3'b111,3'b111,3'b000);  // 3
      // ch1 = 5 mid-period: pending until next wrap.
      add(1,1,5,0, 3'b000,3'b000,3'b010);  // 4
      add(0,0,0,0, 3'b111,3'b111,3'b000);  // 5
      add(0,0,0,0, 3'b010,3'b000,3'b000);  // 6
      add(0,0,0,0, 3'b111,3'b101,3'b000);  // 7
      add(0,0,0,0, 3'b000,3'b000,3'b000);  // 8
      add(0,0,0,0, 3'b101,3'b101,3'b000);  // 9
      add(0,0,0,0, 3'b010,3'b010,3'b000);  // 10
      add(0,0,0,0, 3'b111,3'b101,3'b000);  // 11
      // ch0 = 4 mid-period, then 7 on the period end: only 7 lands.
      add(1,0,4,0, 3'b010,3'b000,3'b001);  // 12
      add(1,0,7,0, 3'b101,3'b101,3'b000);  // 13
      add(0,0,0,0, 3'b001,3'b000,3'b000);  // 14
      add(0,0,0,0, 3'b111,3'b110,3'b000);  // 15
      add(0,0,0,0, 3'b011,3'b000,3'b000);  // 16
      add(0,0,0,0, 3'b110,3'b100,3'b000);  // 17
      add(0,0,0,0, 3'b000,3'b000,3'b000);  // 18
      add(0,0,0,0, 3'b100,3'b100,3'b000);  // 19
      add(0,0,0,0, 3'b011,3'b011,3'b000);  // 20
      add(0,0,0,0, 3'b111,3'b100,3'b000);  // 21
      // ch2 = 0 mid-period: finishes the period, then stops.
      add(1,2,0,0, 3'b011,3'b000,3'b100);  // 22
      add(0,0,0,0, 3'b001,3'b000,3'b000);  // 23
      add(0,0,0,0, 3'b000,3'b000,3'b000);  // 24
      add(0,0,0,0, 3'b010,3'b010,3'b000);  // 25
      // 1 to a stopped channel is ignored; 3 restarts it.
      add(1,2,1,0, 3'b010,3'b000,3'b000);  // 26
      add(1,2,3,0, 3'b011,3'b001,3'b000);  // 27
      add(0,0,0,0, 3'b101,3'b100,3'b000);  // 28
      add(0,0,0,0, 3'b101,3'b000,3'b000);  // 29
      add(0,0,0,0, 3'b011,3'b010,3'b000);  // 30
      add(0,0,0,0, 3'b110,3'b100,3'b000);  // 31
      // ch0 = 4 pending, ch1 = 6 written with calib: all park low.
      add(1,0,4,0, 3'b110,3'b000,3'b001);  // 32
      add(1,1,6,1, 3'b000,3'b000,3'b000);  // 33
      // Out-of-range selects: no effect; channels start in phase.
      add(1,3,9,0, 3'b111,3'b111,3'b000);  // 34
      add(1,3,2,0, 3'b111,3'b000,3'b000);  // 35
      add(0,0,0,0, 3'b010,3'b000,3'b000);  // 36
      add(0,0,0,0, 3'b100,3'b100,3'b000);  // 37
      add(0,0,0,0, 3'b101,3'b001,3'b000);  // 38
      // Calib held high keeps everything low.
      add(0,0,0,1, 3'b000,3'b000,3'b000);  // 39
      add(0,0,0,1, 3'b000,3'b000,3'b000);  // 40
      add(0,0,0,0, 3'b111,3'b111,3'b000);  // 41

      #2;
      chk_all("reset", 3'b000, 3'b000, 3'b000);
      #11 rst_n = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].wr, vq[i].sel, vq[i].data, vq[i].cal);
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", i + 1), vq[i].clk, vq[i].tick, vq[i].pend);
      end

      // Pending write lost to an asynchronous reset between edges.
      drive(1'b1, 2'd1, 8'd5, 1'b0);
      @(posedge clk);
      #1;
      chk_all("pre_rst", 3'b111, 3'b000, 3'b010);
      drive(1'b0, 2'd0, '0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 3'b000, 3'b000, 3'b000);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all("post_rst1", 3'b111, 3'b111, 3'b000);
      @(posedge clk); #1;
      chk_all("post_rst2", 3'b000, 3'b000, 3'b000);
      @(posedge clk); #1;
      chk_all("post_rst3", 3'b111, 3'b111, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
